// File: rtl/axil_cmd_pkg.sv
// Shared types for the CMD/RESP ring consumer that drives an AXI4-Lite master.
// Holds the op and response encodings, the executor state enum and the ring entry structs.
package axil_cmd_pkg;

    localparam int AXIL_ADDR_W = 32;
    localparam int AXIL_DATA_W = 64;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_POP      = 4'd1,
        ST_POP_REL  = 4'd2,
        ST_WR_AW    = 4'd3,
        ST_WR_B     = 4'd4,
        ST_RD_AR    = 4'd5,
        ST_RD_R     = 4'd6,
        ST_PUSH     = 4'd7,
        ST_PUSH_REL = 4'd8
    } exec_state_e;

    typedef struct packed {
        logic                       op;
        logic [AXIL_ADDR_W-1:0]     addr;
        logic [AXIL_DATA_W-1:0]     wdata;
        logic [AXIL_DATA_W/8-1:0]   wstrb;
    } cmd_t;

    typedef struct packed {
        logic                       op;
        logic [AXIL_ADDR_W-1:0]     addr;
        logic [AXIL_DATA_W-1:0]     rdata;
        logic [1:0]                 status;
    } resp_t;

    // Anything other than OKAY counts towards err_count, EXOKAY included.
    function automatic logic is_error(input logic [1:0] status);
        return status != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axil_cmd_executor_reqack.sv
// Four-phase req/ack initiator: start raises req, req is held until ack, done flags the ack cycle.
// The caller keeps req low for at least one cycle by waiting for ack to fall before the next start.
module reqack_initiator (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic ack,
    output logic req,
    output logic done
);

    always_ff @(posedge clk) begin
        if (reset) begin
            req <= 1'b0;
        end else if (start) begin
            req <= 1'b1;
        end else if (req && ack) begin
            req <= 1'b0;
        end
    end

    // Ack only counts while req is up.
    assign done = req & ack;

endmodule

// File: rtl/axil_cmd_executor.sv
// Pops one CMD ring entry, runs it as a single AXI4-Lite transaction and pushes the result to the RESP ring.
// Exactly one transaction is in flight; every control output comes straight from a flop.
module axil_cmd_executor
    import axil_cmd_pkg::*;
#(
    parameter int ADDR_W = AXIL_ADDR_W,
    parameter int DATA_W = AXIL_DATA_W,
    parameter int CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  cmd_empty,
    output logic                  cmd_pop_req,
    input  logic                  cmd_pop_ack,
    input  logic                  cmd_op,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_wstrb,

    output logic                  resp_push_req,
    input  logic                  resp_push_ack,
    output logic                  resp_op,
    output logic [ADDR_W-1:0]     resp_addr,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic [1:0]            resp_status,

    output logic [ADDR_W-1:0]     m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_W-1:0]     m_axil_wdata,
    output logic [DATA_W/8-1:0]   m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_W-1:0]     m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_W-1:0]     m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready,

    output logic                  busy,
    output logic [CNT_W-1:0]      txn_count,
    output logic [CNT_W-1:0]      err_count,
    output exec_state_e           dbg_state
);

    localparam int STRB_W = DATA_W / 8;

    // Handshakes: an AXI transfer happens on the edge where valid and ready are both high; valid never
    // drops before that edge and its payload is frozen while valid is up. Ring req/ack is four-phase:
    // req rises, stays until ack, drops, and the next req waits until ack has fallen again.

    exec_state_e          state_q;
    exec_state_e          state_d;

    logic                 pop_start;
    logic                 pop_done;
    logic                 push_start;
    logic                 push_done;

    logic                 aw_hs;
    logic                 w_hs;
    logic                 ar_hs;
    logic                 b_hs;
    logic                 r_hs;

    logic                 aw_done_q;
    logic                 w_done_q;
    logic                 aw_done_d;
    logic                 w_done_d;
    logic                 awvalid_d;
    logic                 wvalid_d;
    logic                 arvalid_d;
    logic                 bready_d;
    logic                 rready_d;
    logic                 busy_d;

    logic                 op_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [STRB_W-1:0]    wstrb_q;
    logic [DATA_W-1:0]    rdata_q;
    logic [1:0]           status_q;
    logic [CNT_W-1:0]     txn_q;
    logic [CNT_W-1:0]     err_q;

    assign aw_hs = m_axil_awvalid & m_axil_awready;
    assign w_hs  = m_axil_wvalid  & m_axil_wready;
    assign ar_hs = m_axil_arvalid & m_axil_arready;
    assign b_hs  = m_axil_bready  & m_axil_bvalid;
    assign r_hs  = m_axil_rready  & m_axil_rvalid;

    reqack_initiator u_cmd_pop (
        .clk   (clk),
        .reset (reset),
        .start (pop_start),
        .ack   (cmd_pop_ack),
        .req   (cmd_pop_req),
        .done  (pop_done)
    );

    reqack_initiator u_resp_push (
        .clk   (clk),
        .reset (reset),
        .start (push_start),
        .ack   (resp_push_ack),
        .req   (resp_push_req),
        .done  (push_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (!cmd_empty)    state_d = ST_POP;
            ST_POP:      if (pop_done)      state_d = ST_POP_REL;
            ST_POP_REL:  if (!cmd_pop_ack)  state_d = (op_q == OP_WRITE) ? ST_WR_AW : ST_RD_AR;
            ST_WR_AW:    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = ST_WR_B;
            ST_WR_B:     if (b_hs)          state_d = ST_PUSH;
            ST_RD_AR:    if (ar_hs)         state_d = ST_RD_R;
            ST_RD_R:     if (r_hs)          state_d = ST_PUSH;
            ST_PUSH:     if (push_done)     state_d = ST_PUSH_REL;
            ST_PUSH_REL: if (!resp_push_ack) state_d = ST_IDLE;
            default:                        state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so each one is a clean flop.
    always_comb begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (state_q == ST_WR_AW) begin
            aw_done_d = aw_done_q | aw_hs;
            w_done_d  = w_done_q | w_hs;
        end
        awvalid_d  = (state_d == ST_WR_AW) && !aw_done_d;
        wvalid_d   = (state_d == ST_WR_AW) && !w_done_d;
        arvalid_d  = (state_d == ST_RD_AR);
        bready_d   = (state_d == ST_WR_B);
        rready_d   = (state_d == ST_RD_R);
        busy_d     = (state_d != ST_IDLE);
        pop_start  = (state_q == ST_IDLE) && (state_d == ST_POP);
        push_start = (state_q != ST_PUSH) && (state_d == ST_PUSH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            aw_done_q      <= 1'b0;
            w_done_q       <= 1'b0;
            m_axil_awvalid <= 1'b0;
            m_axil_wvalid  <= 1'b0;
            m_axil_arvalid <= 1'b0;
            m_axil_bready  <= 1'b0;
            m_axil_rready  <= 1'b0;
            busy           <= 1'b0;
        end else begin
            aw_done_q      <= aw_done_d;
            w_done_q       <= w_done_d;
            m_axil_awvalid <= awvalid_d;
            m_axil_wvalid  <= wvalid_d;
            m_axil_arvalid <= arvalid_d;
            m_axil_bready  <= bready_d;
            m_axil_rready  <= rready_d;
            busy           <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rdata_q  <= '0;
            status_q <= 2'b00;
        end else begin
            if (state_q == ST_POP && pop_done) begin
                op_q    <= cmd_op;
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
            end
            if (state_q == ST_WR_B && b_hs) begin
                rdata_q  <= '0;
                status_q <= m_axil_bresp;
            end else if (state_q == ST_RD_R && r_hs) begin
                rdata_q  <= m_axil_rdata;
                status_q <= m_axil_rresp;
            end
        end
    end

    // Counters are free-running and wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            txn_q <= '0;
            err_q <= '0;
        end else if (state_q == ST_PUSH && push_done) begin
            txn_q <= txn_q + 1'b1;
            if (is_error(status_q)) begin
                err_q <= err_q + 1'b1;
            end
        end
    end

    assign resp_op       = op_q;
    assign resp_addr     = addr_q;
    assign resp_rdata    = rdata_q;
    assign resp_status   = status_q;
    assign m_axil_awaddr = addr_q;
    assign m_axil_awprot = 3'b000;
    assign m_axil_wdata  = wdata_q;
    assign m_axil_wstrb  = wstrb_q;
    assign m_axil_araddr = addr_q;
    assign m_axil_arprot = 3'b000;
    assign txn_count     = txn_q;
    assign err_count     = err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_axil_cmd_executor.sv
// Bench for axil_cmd_executor: ring pop/push responders, a delay-programmable AXI-Lite slave,
// a response scoreboard, a table of directed vectors, randomized transactions and a reset abort.
module tb_axil_cmd_executor;
    import axil_cmd_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int CNT_W  = 32;
    localparam int RESP_W = $bits(resp_t);

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                cmd_empty;
    logic                cmd_pop_req;
    logic                cmd_pop_ack;
    logic                cmd_op;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_wdata;
    logic [DATA_W/8-1:0] cmd_wstrb;
    logic                resp_push_req;
    logic                resp_push_ack;
    logic                resp_op;
    logic [ADDR_W-1:0]   resp_addr;
    logic [DATA_W-1:0]   resp_rdata;
    logic [1:0]          resp_status;
    logic [ADDR_W-1:0]   m_axil_awaddr;
    logic [2:0]          m_axil_awprot;
    logic                m_axil_awvalid;
    logic                m_axil_awready;
    logic [DATA_W-1:0]   m_axil_wdata;
    logic [DATA_W/8-1:0] m_axil_wstrb;
    logic                m_axil_wvalid;
    logic                m_axil_wready;
    logic [1:0]          m_axil_bresp;
    logic                m_axil_bvalid;
    logic                m_axil_bready;
    logic [ADDR_W-1:0]   m_axil_araddr;
    logic [2:0]          m_axil_arprot;
    logic                m_axil_arvalid;
    logic                m_axil_arready;
    logic [DATA_W-1:0]   m_axil_rdata;
    logic [1:0]          m_axil_rresp;
    logic                m_axil_rvalid;
    logic                m_axil_rready;
    logic                busy;
    logic [CNT_W-1:0]    txn_count;
    logic [CNT_W-1:0]    err_count;
    exec_state_e         dbg_state;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    axil_cmd_executor #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .cmd_empty(cmd_empty), .cmd_pop_req(cmd_pop_req), .cmd_pop_ack(cmd_pop_ack),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .resp_push_req(resp_push_req), .resp_push_ack(resp_push_ack), .resp_op(resp_op),
        .resp_addr(resp_addr), .resp_rdata(resp_rdata), .resp_status(resp_status),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot), .m_axil_awvalid(m_axil_awvalid),
        .m_axil_awready(m_axil_awready), .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready), .m_axil_bresp(m_axil_bresp),
        .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready), .m_axil_araddr(m_axil_araddr),
        .m_axil_arprot(m_axil_arprot), .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp), .m_axil_rvalid(m_axil_rvalid),
        .m_axil_rready(m_axil_rready), .busy(busy), .txn_count(txn_count), .err_count(err_count),
        .dbg_state(dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name, input string got, input string want);
        total++;
        bad++;
        $display("FAIL %s: got %s expected %s", name, got, want);
    endtask

    // Slave behaviour for the transaction in flight.
    int               aw_dly, w_dly, ar_dly, b_dly, r_dly;
    logic [1:0]       cfg_bresp, cfg_rresp;
    logic [DATA_W-1:0] cfg_rdata;
    logic [ADDR_W-1:0] cap_awaddr, cap_araddr;
    logic [DATA_W-1:0] cap_wdata;
    logic [7:0]       cap_wstrb;
    int               aw_n, w_n, ar_n, split_n;

    cmd_t             cmd_q[$];
    logic [RESP_W-1:0] exp_q[$];
    int               n_resp = 0;
    int               exp_txn = 0;
    int               exp_err = 0;

    // ---------------- CMD ring pop responder ----------------
    initial begin
        cmd_t c;
        cmd_pop_ack = 1'b0; cmd_empty = 1'b1;
        cmd_op = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cmd_pop_ack = 1'b0;
            end else if (cmd_pop_req && !cmd_pop_ack) begin
                if (cmd_q.size() == 0) begin
                    flag_fail("pop_while_empty", "pop_req=1", "no pop");
                end else begin
                    c = cmd_q.pop_front();
                    cmd_op = c.op; cmd_addr = c.addr; cmd_wdata = c.wdata; cmd_wstrb = c.wstrb;
                    cmd_pop_ack = 1'b1;
                end
            end else if (!cmd_pop_req && cmd_pop_ack) begin
                cmd_pop_ack = 1'b0;
            end
            cmd_empty = (cmd_q.size() == 0);
        end
    end

    // ---------------- RESP ring push collector + scoreboard ----------------
    initial begin
        resp_t e;
        resp_push_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                resp_push_ack = 1'b0;
            end else if (resp_push_req && !resp_push_ack) begin
                if (exp_q.size() == 0) begin
                    flag_fail("unexpected_push", $sformatf("push addr 0x%0h", resp_addr), "no push");
                end else begin
                    e = exp_q.pop_front();
                    check("resp_op", resp_op, e.op);
                    check("resp_addr", resp_addr, e.addr);
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_status", resp_status, e.status);
                end
                n_resp++;
                resp_push_ack = 1'b1;
            end else if (!resp_push_req && resp_push_ack) begin
                resp_push_ack = 1'b0;
            end
        end
    end

    // ---------------- AXI-Lite slave: address/data channels ----------------
    initial begin
        int cnt;
        cnt = 0; aw_n = 0; m_axil_awready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_axil_awready = 1'b0; cnt = 0; aw_n = 0;
            end else if (m_axil_awready) begin
                m_axil_awready = 1'b0; aw_n++; cnt = 0;
            end else if (m_axil_awvalid) begin
                if (cnt >= aw_dly) begin
                    m_axil_awready = 1'b1; cap_awaddr = m_axil_awaddr;
                end else begin
                    cnt++;
                end
            end else if (cnt != 0) begin
                flag_fail("awvalid_dropped", "awvalid=0", "held until awready"); cnt = 0;
            end
        end
    end

    initial begin
        int cnt;
        cnt = 0; w_n = 0; split_n = 0; m_axil_wready = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && m_axil_wvalid && !m_axil_awvalid) split_n++;
            if (reset) begin
                m_axil_wready = 1'b0; cnt = 0; w_n = 0;
            end else if (m_axil_wready) begin
                m_axil_wready = 1'b0; w_n++; cnt = 0;
            end else if (m_axil_wvalid) begin
                if (cnt >= w_dly) begin
                    m_axil_wready = 1'b1; cap_wdata = m_axil_wdata; cap_wstrb = m_axil_wstrb;
                end else begin
                    cnt++;
                end
            end else if (cnt != 0) begin
                flag_fail("wvalid_dropped", "wvalid=0", "held until wready"); cnt = 0;
            end
        end
    end

    initial begin
        int cnt;
        cnt = 0; ar_n = 0; m_axil_arready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_axil_arready = 1'b0; cnt = 0; ar_n = 0;
            end else if (m_axil_arready) begin
                m_axil_arready = 1'b0; ar_n++; cnt = 0;
            end else if (m_axil_arvalid) begin
                if (cnt >= ar_dly) begin
                    m_axil_arready = 1'b1; cap_araddr = m_axil_araddr;
                end else begin
                    cnt++;
                end
            end else if (cnt != 0) begin
                flag_fail("arvalid_dropped", "arvalid=0", "held until arready"); cnt = 0;
            end
        end
    end

    // ---------------- AXI-Lite slave: response channels ----------------
    initial begin
        int cnt, b_n;
        bit pend;
        cnt = 0; b_n = 0; pend = 0; m_axil_bvalid = 1'b0; m_axil_bresp = 2'b00;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_axil_bvalid = 1'b0; cnt = 0; b_n = 0; pend = 0;
            end else if (pend) begin
                m_axil_bvalid = 1'b0; pend = 0; b_n++; cnt = 0;
            end else begin
                if (!m_axil_bvalid && aw_n > b_n && w_n > b_n) begin
                    if (cnt >= b_dly) begin
                        m_axil_bvalid = 1'b1; m_axil_bresp = cfg_bresp;
                    end else begin
                        cnt++;
                    end
                end
                if (m_axil_bvalid && m_axil_bready) pend = 1;
            end
        end
    end

    initial begin
        int cnt, r_n;
        bit pend;
        cnt = 0; r_n = 0; pend = 0;
        m_axil_rvalid = 1'b0; m_axil_rresp = 2'b00; m_axil_rdata = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_axil_rvalid = 1'b0; cnt = 0; r_n = 0; pend = 0;
            end else if (pend) begin
                m_axil_rvalid = 1'b0; pend = 0; r_n++; cnt = 0;
            end else begin
                if (!m_axil_rvalid && ar_n > r_n) begin
                    if (cnt >= r_dly) begin
                        m_axil_rvalid = 1'b1; m_axil_rresp = cfg_rresp; m_axil_rdata = cfg_rdata;
                    end else begin
                        cnt++;
                    end
                end
                if (m_axil_rvalid && m_axil_rready) pend = 1;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic resp_t model_resp(input cmd_t c, input logic [1:0] br, input logic [1:0] rr,
                                         input logic [DATA_W-1:0] rd);
        resp_t r;
        r.op     = c.op;
        r.addr   = c.addr;
        r.rdata  = (c.op == OP_WRITE) ? '0 : rd;
        r.status = (c.op == OP_WRITE) ? br : rr;
        return r;
    endfunction

    task automatic set_cfg(input int awd, input int wd, input int ard, input int bd, input int rd,
                           input logic [1:0] br, input logic [1:0] rr, input logic [DATA_W-1:0] data);
        aw_dly = awd; w_dly = wd; ar_dly = ard; b_dly = bd; r_dly = rd;
        cfg_bresp = br; cfg_rresp = rr; cfg_rdata = data;
    endtask

    task automatic wait_resp(input int target);
        for (int i = 0; i < 400 && n_resp < target; i++) @(negedge clk);
        check("resp_count", n_resp, target);
    endtask

    task automatic check_counters(input string tag);
        repeat (3) @(negedge clk);
        check({tag, "_txn"}, txn_count, exp_txn);
        check({tag, "_err"}, err_count, exp_err);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        cmd_t       cmd;
        int         aw_d, w_d, ar_d, b_d, r_d;
        logic [1:0] bresp, rresp;
        logic [DATA_W-1:0] rdata;
        resp_t      exp;
        int         txn, err;
        bit         split;
    } vec_t;

    vec_t vecs[5];

    initial begin
        cmd_t  c;
        resp_t e;
        int    split_before, n_before;

        set_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, '0);

        vecs[0] = '{cmd: '{op: 1'b1, addr: 32'h0000_1000, wdata: 64'hDEADBEEF_CAFEF00D, wstrb: 8'hFF},
                    aw_d: 0, w_d: 0, ar_d: 0, b_d: 0, r_d: 0, bresp: 2'b00, rresp: 2'b00, rdata: 64'h0,
                    exp: '{op: 1'b1, addr: 32'h0000_1000, rdata: 64'h0, status: 2'b00},
                    txn: 1, err: 0, split: 1'b0};
        vecs[1] = '{cmd: '{op: 1'b1, addr: 32'h0000_1004, wdata: 64'h1111_2222_3333_4444, wstrb: 8'h0F},
                    aw_d: 1, w_d: 4, ar_d: 0, b_d: 1, r_d: 0, bresp: 2'b00, rresp: 2'b00, rdata: 64'h0,
                    exp: '{op: 1'b1, addr: 32'h0000_1004, rdata: 64'h0, status: 2'b00},
                    txn: 2, err: 0, split: 1'b1};
        vecs[2] = '{cmd: '{op: 1'b0, addr: 32'h0000_2008, wdata: 64'hFFFF_0000_FFFF_0000, wstrb: 8'hAA},
                    aw_d: 0, w_d: 0, ar_d: 3, b_d: 0, r_d: 0, bresp: 2'b00, rresp: 2'b00,
                    rdata: 64'h01234567_89ABCDEF,
                    exp: '{op: 1'b0, addr: 32'h0000_2008, rdata: 64'h01234567_89ABCDEF, status: 2'b00},
                    txn: 3, err: 0, split: 1'b0};
        vecs[3] = '{cmd: '{op: 1'b0, addr: 32'h0000_3000, wdata: 64'h0, wstrb: 8'h00},
                    aw_d: 0, w_d: 0, ar_d: 0, b_d: 0, r_d: 2, bresp: 2'b00, rresp: 2'b10,
                    rdata: 64'h0000_0000_0000_5555,
                    exp: '{op: 1'b0, addr: 32'h0000_3000, rdata: 64'h0000_0000_0000_5555, status: 2'b10},
                    txn: 4, err: 1, split: 1'b0};
        vecs[4] = '{cmd: '{op: 1'b1, addr: 32'h0000_4000, wdata: 64'h0123_0000_0000_3210, wstrb: 8'h81},
                    aw_d: 2, w_d: 0, ar_d: 0, b_d: 2, r_d: 0, bresp: 2'b11, rresp: 2'b00, rdata: 64'h0,
                    exp: '{op: 1'b1, addr: 32'h0000_4000, rdata: 64'h0, status: 2'b11},
                    txn: 5, err: 2, split: 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pop_req", cmd_pop_req, 1'b0);
        check("rst_push_req", resp_push_req, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_awvalid", m_axil_awvalid, 1'b0);
        check("rst_arvalid", m_axil_arvalid, 1'b0);
        check("rst_txn", txn_count, 0);
        check("rst_err", err_count, 0);
        check("rst_addr", m_axil_awaddr, 0);
        reset = 1'b0;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 5; i++) begin
            set_cfg(vecs[i].aw_d, vecs[i].w_d, vecs[i].ar_d, vecs[i].b_d, vecs[i].r_d,
                    vecs[i].bresp, vecs[i].rresp, vecs[i].rdata);
            split_before = split_n;
            exp_q.push_back(vecs[i].exp);
            cmd_q.push_back(vecs[i].cmd);
            wait_resp(n_resp + 1);
            exp_txn = vecs[i].txn;
            exp_err = vecs[i].err;
            check_counters($sformatf("vec%0d", i));
            if (vecs[i].cmd.op == OP_WRITE) begin
                check($sformatf("vec%0d_awaddr", i), cap_awaddr, vecs[i].cmd.addr);
                check($sformatf("vec%0d_wdata", i), cap_wdata, vecs[i].cmd.wdata);
                check($sformatf("vec%0d_wstrb", i), cap_wstrb, vecs[i].cmd.wstrb);
                check($sformatf("vec%0d_aw_first", i), split_n != split_before, vecs[i].split);
            end else begin
                check($sformatf("vec%0d_araddr", i), cap_araddr, vecs[i].cmd.addr);
            end
        end

        // Empty ring: no pop may be raised
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("empty_pop_req", cmd_pop_req, 1'b0);
            check("empty_busy", busy, 1'b0);
        end

        // Three queued commands drain back to back, in order
        set_cfg(0, 0, 0, 0, 0, 2'b00, 2'b01, 64'hA5A5_5A5A_0F0F_F0F0);
        n_before = n_resp;
        for (int i = 0; i < 3; i++) begin
            c.op    = (i == 1) ? OP_READ : OP_WRITE;
            c.addr  = 32'h0000_6000 + 32'(i * 8);
            c.wdata = {32'(i), 32'hBEEF_0000};
            c.wstrb = 8'hF0;
            e = model_resp(c, cfg_bresp, cfg_rresp, cfg_rdata);
            exp_txn++;
            if (e.status != RESP_OKAY) exp_err++;
            exp_q.push_back(e);
            cmd_q.push_back(c);
        end
        wait_resp(n_before + 3);
        check_counters("queued");

        // Randomized single transactions against the model
        for (int i = 0; i < 25; i++) begin
            set_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), {$urandom, $urandom});
            c.op    = 1'($urandom_range(0, 1));
            c.addr  = $urandom & 32'hFFFF_FFF8;
            c.wdata = {$urandom, $urandom};
            c.wstrb = 8'($urandom_range(0, 255));
            e = model_resp(c, cfg_bresp, cfg_rresp, cfg_rdata);
            exp_txn++;
            if (e.status != RESP_OKAY) exp_err++;
            exp_q.push_back(e);
            cmd_q.push_back(c);
            wait_resp(n_resp + 1);
            if (c.op == OP_WRITE) check("rnd_awaddr", cap_awaddr, c.addr);
            else                  check("rnd_araddr", cap_araddr, c.addr);
        end
        check_counters("random");

        // Reset while waiting for read data: transaction abandoned, nothing pushed
        set_cfg(0, 0, 0, 0, 40, 2'b00, 2'b00, 64'h77);
        c.op = OP_READ; c.addr = 32'h0000_5000; c.wdata = '0; c.wstrb = '0;
        cmd_q.push_back(c);
        for (int i = 0; i < 100 && !m_axil_rready; i++) @(negedge clk);
        check("reach_rd_r", m_axil_rready, 1'b1);
        n_before = n_resp;
        reset = 1'b1;
        @(negedge clk);
        check("abort_arvalid", m_axil_arvalid, 1'b0);
        check("abort_rready", m_axil_rready, 1'b0);
        check("abort_pop_req", cmd_pop_req, 1'b0);
        check("abort_push_req", resp_push_req, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_txn", txn_count, 0);
        check("abort_err", err_count, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_txn = 0;
        exp_err = 0;
        repeat (60) @(negedge clk);
        check("abort_no_push", n_resp, n_before);

        // Recovery after the abort
        set_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, '0);
        c.op = OP_WRITE; c.addr = 32'h0000_7000; c.wdata = 64'h1; c.wstrb = 8'h01;
        exp_q.push_back(model_resp(c, cfg_bresp, cfg_rresp, cfg_rdata));
        exp_txn = 1;
        cmd_q.push_back(c);
        wait_resp(n_resp + 1);
        check_counters("recover");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        total++;
        bad++;
        $display("FAIL watchdog: got timeout expected test completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
